// File: rtl/ahb_lite_master.sv
// ahb_lite_master
//   AHB-Lite initiator. Turns a valid/ready command stream into single
//   NONSEQ transfers (no bursts) and returns one registered response per
//   command, in command order. Address and data phases are pipelined, so a
//   zero-wait bus carries one transfer per cycle.
//
// Ports
//   HCLK, HRESET            bus clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_addr                byte address (ADDR_WIDTH)
//   cmd_write               1 = write, 0 = read
//   cmd_size                0 byte, 1 halfword, 2 word, 3 always misaligned
//   cmd_wdata               right-justified write data
//   rsp_valid               one-cycle response pulse, no backpressure
//   rsp_rdata               right-justified, zero-extended read data (0 for
//                           writes and errors)
//   rsp_error               misaligned command rejected
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA   AHB-Lite master outputs
//   HRDATA/HREADY           AHB-Lite slave-side inputs
module ahb_lite_master #(
  parameter int ADDR_WIDTH  = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [1:0]            cmd_size,
  input  logic [31:0]           cmd_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [31:0]           HWDATA,
  input  logic [31:0]           HRDATA,
  input  logic                  HREADY
);

  localparam int DATA_W = 32;

  function automatic logic misaligned(input logic [1:0] lane, input logic [1:0] size);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return lane[0];
      2'd2:    return lane != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  // Narrow writes are copied onto every lane so the slave can pick the
  // lane selected by HADDR[1:0] without the master shifting data.
  function automatic logic [DATA_W-1:0] replicate(input logic [DATA_W-1:0] d,
                                                  input logic [1:0]        size);
    case (size)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] d,
                                                input logic [1:0]        size,
                                                input logic [1:0]        lane);
    case (size)
      2'd0:    return {24'd0, d[8*lane +: 8]};
      2'd1:    return {16'd0, d[16*lane[1] +: 16]};
      default: return d;
    endcase
  endfunction

  logic                  vld_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic                  write_p0;
  logic [1:0]            size_p0;
  logic [DATA_W-1:0]     wdata_p0;

  logic                  vld_p1;
  logic                  write_p1;
  logic [1:0]            size_p1;
  logic [1:0]            lane_p1;
  logic [DATA_W-1:0]     hwdata_p1;

  logic                  vld_p2;
  logic                  err_p2;
  logic [DATA_W-1:0]     rdata_p2;

  logic cmd_mis;
  logic accept;
  logic accept_bus;
  logic accept_err;
  logic advance;
  logic complete;

  assign cmd_mis = CHECK_ALIGN && misaligned(cmd_addr[1:0], cmd_size);

  // A rejected command answers on its own one cycle after accept, so it
  // must wait for an empty pipeline or it would overtake older responses.
  always_comb begin
    cmd_ready = 1'b0;
    if (!HRESET) begin
      if (cmd_mis) cmd_ready = !vld_p0 && !vld_p1;
      else         cmd_ready = !vld_p0 || HREADY;
    end
  end

  assign accept     = cmd_valid && cmd_ready;
  assign accept_bus = accept && !cmd_mis;
  assign accept_err = accept && cmd_mis;
  assign advance    = HREADY && vld_p0;
  assign complete   = HREADY && vld_p1;

  // ---- address stage (p0): drives HADDR/HTRANS/HWRITE/HSIZE ----
  // An accept while vld_p0 is set implies HREADY, so the current address
  // phase is leaving on the same edge and the new one replaces it.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      vld_p0   <= 1'b0;
      addr_p0  <= '0;
      write_p0 <= 1'b0;
      size_p0  <= 2'd0;
    end else if (accept_bus) begin
      vld_p0   <= 1'b1;
      addr_p0  <= cmd_addr;
      write_p0 <= cmd_write;
      size_p0  <= cmd_size;
    end else if (advance) begin
      vld_p0   <= 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (accept_bus) wdata_p0 <= cmd_wdata;
  end

  // ---- data stage (p1): HWDATA held until the data phase completes ----
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      vld_p1    <= 1'b0;
      hwdata_p1 <= '0;
    end else if (advance) begin
      vld_p1    <= 1'b1;
      hwdata_p1 <= replicate(wdata_p0, size_p0);
    end else if (complete) begin
      vld_p1    <= 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (advance) begin
      write_p1 <= write_p0;
      size_p1  <= size_p0;
      lane_p1  <= addr_p0[1:0];
    end
  end

  // ---- response stage (p2): one-cycle pulse ----
  // complete and accept_err never coincide: accept_err needs vld_p1 low.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      vld_p2   <= 1'b0;
      err_p2   <= 1'b0;
      rdata_p2 <= '0;
    end else if (complete) begin
      vld_p2   <= 1'b1;
      err_p2   <= 1'b0;
      rdata_p2 <= write_p1 ? '0 : extract(HRDATA, size_p1, lane_p1);
    end else if (accept_err) begin
      vld_p2   <= 1'b1;
      err_p2   <= 1'b1;
      rdata_p2 <= '0;
    end else begin
      vld_p2   <= 1'b0;
      err_p2   <= 1'b0;
      rdata_p2 <= '0;
    end
  end

  assign HADDR     = addr_p0;
  assign HTRANS    = vld_p0 ? 2'b10 : 2'b00;
  assign HWRITE    = write_p0;
  assign HSIZE     = {1'b0, size_p0};
  assign HWDATA    = hwdata_p1;
  assign rsp_valid = vld_p2;
  assign rsp_error = err_p2;
  assign rsp_rdata = rdata_p2;

endmodule

// File: tb/tb_ahb_lite_master.sv
module tb_ahb_lite_master;

  logic        HCLK;
  logic        HRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;

  ahb_lite_master #(.ADDR_WIDTH(32), .CHECK_ALIGN(1'b1)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // ---------------- RAM slave (256 bytes, HREADY driven by the bench) ----
  logic [31:0] mem [0:63];
  logic        clear_mem;
  logic        s_dvalid;
  logic        s_write;
  logic [7:0]  s_addr;
  logic [1:0]  s_size;

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      s_dvalid <= 1'b0;
      if (clear_mem) begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      end
    end else if (HREADY) begin
      if (s_dvalid && s_write) begin
        case (s_size)
          2'd0:    mem[s_addr[7:2]][8*s_addr[1:0] +: 8]  <= HWDATA[8*s_addr[1:0] +: 8];
          2'd1:    mem[s_addr[7:2]][16*s_addr[1] +: 16]  <= HWDATA[16*s_addr[1] +: 16];
          default: mem[s_addr[7:2]] <= HWDATA;
        endcase
      end
      s_dvalid <= (HTRANS == 2'b10);
      s_addr   <= HADDR[7:0];
      s_write  <= HWRITE;
      s_size   <= HSIZE[1:0];
    end
  end

  assign HRDATA = (s_dvalid && !s_write) ? mem[s_addr[7:2]] : 32'h0;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] refmem [0:255];
  int         checks;
  int         errors;
  int         rsp_count;
  logic       rand_hr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  // Reference: little-endian byte memory updated in command order.
  function automatic exp_t model(input logic [31:0] addr, input logic wr,
                                 input logic [1:0] size, input logic [31:0] wdata);
    exp_t        e;
    int          n;
    logic [31:0] r;
    e.err   = 1'b0;
    e.rdata = 32'h0;
    r       = 32'h0;
    if (size == 2'd3 || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00)) begin
      e.err = 1'b1;
      return e;
    end
    n = 1 << size;
    for (int k = 0; k < n; k++) begin
      if (wr) refmem[int'(addr[7:0]) + k] = wdata[8*k +: 8];
      else    r[8*k +: 8] = refmem[int'(addr[7:0]) + k];
    end
    if (!wr) e.rdata = r;
    return e;
  endfunction

  task automatic step();
    @(posedge HCLK);
    #1;
    if (rand_hr) HREADY = ($urandom_range(0, 1) == 1);
  endtask

  // Offers one command; returns one cycle after the accepting edge.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                       input logic [31:0] wdata, output int waits);
    logic ok;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_write = wr;
    cmd_size  = size;
    cmd_wdata = wdata;
    waits     = 0;
    forever begin
      @(negedge HCLK);
      ok = cmd_ready;
      if (ok) exp_q.push_back(model(addr, wr, size, wdata));
      step();
      if (ok) break;
      waits++;
      if (waits > 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: addr 0x%08h not accepted in %0d cycles", addr, waits);
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    step();
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (!HRESET && rsp_valid) begin
        rsp_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid with rdata 0x%08h, expected no response", rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          chk1("rsp_error", rsp_error, e.err);
          chk("rsp_rdata", rsp_rdata, e.rdata);
        end
      end
    end
  endtask

  // Address/control must not move across an edge with HREADY low, and
  // neither may the write data of a stalled data phase.
  task automatic proto_loop();
    logic        ok;
    logic        ph;
    logic        pdw;
    logic [31:0] pa;
    logic [1:0]  pt;
    logic        pw;
    logic [2:0]  ps;
    logic [31:0] pd;
    ok = 1'b0;
    ph = 1'b1; pdw = 1'b0; pa = 32'h0; pt = 2'b00; pw = 1'b0; ps = 3'd0; pd = 32'h0;
    forever begin
      @(negedge HCLK);
      if (!HRESET && ok && !ph) begin
        if (pt == 2'b10) begin
          chk("haddr_hold", HADDR, pa);
          chk("ctrl_hold", {26'd0, HTRANS, HWRITE, HSIZE}, {26'd0, pt, pw, ps});
        end
        if (pdw) chk("hwdata_hold", HWDATA, pd);
      end
      ok  = !HRESET;
      ph  = HREADY;
      pdw = s_dvalid && s_write;
      pa  = HADDR;
      pt  = HTRANS;
      pw  = HWRITE;
      ps  = HSIZE;
      pd  = HWDATA;
    end
  endtask

  initial begin
    int          w;
    int          cnt0;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        wr;

    HRESET = 1'b1; HREADY = 1'b1; clear_mem = 1'b1; rand_hr = 1'b0;
    cmd_valid = 1'b0; cmd_addr = 32'h0; cmd_write = 1'b0; cmd_size = 2'd0; cmd_wdata = 32'h0;
    checks = 0; errors = 0; rsp_count = 0;
    for (int i = 0; i < 256; i++) refmem[i] = 8'h00;

    fork
      monitor_loop();
      proto_loop();
    join_none

    // Reset state
    repeat (3) @(posedge HCLK);
    #1;
    chk1("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_haddr", HADDR, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_rsp_error", rsp_error, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    clear_mem = 1'b0;

    // Word write then back-to-back read of the same address
    issue(32'h10, 1'b1, 2'd2, 32'hDEADBEEF, w);
    chk("t1_wr_htrans", 32'(HTRANS), 32'h2);
    chk1("t1_wr_hwrite", HWRITE, 1'b1);
    chk("t1_wr_haddr", HADDR, 32'h10);
    issue(32'h10, 1'b0, 2'd2, 32'h0, w);
    chk("t1_rd_waits", 32'(w), 32'h0);
    chk("t1_rd_htrans", 32'(HTRANS), 32'h2);
    chk1("t1_rd_hwrite", HWRITE, 1'b0);
    chk("t1_wr_hwdata", HWDATA, 32'hDEADBEEF);
    step();
    chk1("t1_wr_rsp_valid", rsp_valid, 1'b1);
    chk("t1_wr_rsp_rdata", rsp_rdata, 32'h0);
    step();
    chk1("t1_rd_rsp_valid", rsp_valid, 1'b1);
    chk("t1_rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    drain();

    // Byte write with lane replication, then word and byte reads
    issue(32'h13, 1'b1, 2'd0, 32'h123456A5, w);
    chk("t2_hsize", 32'(HSIZE), 32'h0);
    step();
    chk("t2_hwdata", HWDATA, 32'hA5A5A5A5);
    drain();
    issue(32'h10, 1'b0, 2'd2, 32'h0, w);
    step();
    step();
    chk1("t2_word_rsp_valid", rsp_valid, 1'b1);
    chk("t2_word_rdata", rsp_rdata, 32'hA5ADBEEF);
    drain();
    issue(32'h13, 1'b0, 2'd0, 32'h0, w);
    step();
    step();
    chk("t2_byte_rdata", rsp_rdata, 32'h000000A5);
    drain();

    // Halfword read with two wait states; a word read waits in address phase
    issue(32'h12, 1'b0, 2'd1, 32'h0, w);
    issue(32'h10, 1'b0, 2'd2, 32'h0, w);
    HREADY = 1'b0;
    #1;
    chk1("t3_ready_wait1", cmd_ready, 1'b0);
    chk("t3_haddr_wait1", HADDR, 32'h10);
    chk("t3_htrans_wait1", 32'(HTRANS), 32'h2);
    step();
    chk1("t3_ready_wait2", cmd_ready, 1'b0);
    chk("t3_haddr_wait2", HADDR, 32'h10);
    chk1("t3_no_rsp_wait2", rsp_valid, 1'b0);
    step();
    HREADY = 1'b1;
    #1;
    chk1("t3_no_rsp_last", rsp_valid, 1'b0);
    step();
    chk1("t3_rsp_valid", rsp_valid, 1'b1);
    chk("t3_rsp_rdata", rsp_rdata, 32'h0000A5AD);
    drain();

    // Misaligned read offered while a write is in flight
    issue(32'h20, 1'b1, 2'd2, 32'hCAFEF00D, w);
    issue(32'h02, 1'b0, 2'd2, 32'h0, w);
    chk("t4_mis_wait_cycles", 32'(w), 32'h2);
    chk("t4_htrans_idle", 32'(HTRANS), 32'h0);
    chk1("t4_rsp_valid", rsp_valid, 1'b1);
    chk1("t4_rsp_error", rsp_error, 1'b1);
    chk("t4_rsp_rdata", rsp_rdata, 32'h0);
    drain();

    // Reset during a stalled data phase abandons the read
    issue(32'h30, 1'b0, 2'd2, 32'h55AA55AA, w);
    step();
    HREADY = 1'b0;
    step();
    HRESET = 1'b1;
    #1;
    chk("t5_htrans", 32'(HTRANS), 32'h0);
    chk("t5_haddr", HADDR, 32'h0);
    chk("t5_hwdata", HWDATA, 32'h0);
    chk1("t5_cmd_ready", cmd_ready, 1'b0);
    chk1("t5_rsp_valid", rsp_valid, 1'b0);
    exp_q.delete();
    step();
    step();
    HREADY = 1'b1;
    HRESET = 1'b0;
    cnt0 = rsp_count;
    repeat (4) step();
    chk("t5_no_rsp_after_reset", 32'(rsp_count - cnt0), 32'h0);
    issue(32'h10, 1'b0, 2'd2, 32'h0, w);
    drain();

    // 16 back-to-back word writes with random HREADY
    rand_hr = 1'b1;
    cnt0 = rsp_count;
    for (int i = 0; i < 16; i++) issue(32'h40 + 32'(4 * i), 1'b1, 2'd2, $urandom, w);
    drain();
    chk("t6_rsp_count", 32'(rsp_count - cnt0), 32'd16);
    for (int i = 0; i < 16; i++) issue(32'h40 + 32'(4 * i), 1'b0, 2'd2, 32'h0, w);
    drain();

    // Random mix of sizes, directions and alignments
    for (int i = 0; i < 80; i++) begin
      a  = 32'($urandom_range(0, 255));
      sz = 2'($urandom_range(0, 3));
      wr = 1'($urandom_range(0, 1));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~((32'h1 << sz) - 32'h1);
      issue(a, wr, sz, $urandom, w);
    end
    drain();
    rand_hr = 1'b0;
    HREADY = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
